// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's ROM bus, IF/ID outputs and pipeline control inputs.
// id_adel_o exists only when IF_ADDR_CHECK_EN is defined.
interface if_fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              stall_i;
    logic              flush_i;
    logic [ADDR_W-1:0] new_pc_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [INST_W-1:0] rom_inst_i;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic              id_valid_o;
`ifdef IF_ADDR_CHECK_EN
    logic              id_adel_o;
`endif

    // The fetch stage itself
    modport master (
        input  stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_inst_i,
`ifdef IF_ADDR_CHECK_EN
        output id_adel_o,
`endif
        output rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o
    );

    // ROM, decode stage and hazard/exception control
    modport slave (
        output stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_inst_i,
`ifdef IF_ADDR_CHECK_EN
        input  id_adel_o,
`endif
        input  rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, ROM drive and IF/ID pipeline register.
// Optional misaligned-fetch trap (id_adel_o + HALT state) enabled by IF_ADDR_CHECK_EN.
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_stage_if.master  bus
);

`ifdef IF_ADDR_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN} state_e;
`endif

    state_e            state_q, state_d;
    logic              rom_ce_q, rom_ce_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic              id_valid_q, id_valid_d;
`ifdef IF_ADDR_CHECK_EN
    logic              id_adel_q, id_adel_d;
`endif

    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the case infers a latch.
        state_d    = state_q;
        rom_ce_d   = rom_ce_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
`ifdef IF_ADDR_CHECK_EN
        id_adel_d  = id_adel_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                state_d    = S_RUN;
                rom_ce_d   = 1'b1;
                pc_d       = RESET_PC;
                id_pc_d    = '0;
                id_inst_d  = '0;
                id_valid_d = 1'b0;
            end

            S_RUN: begin
                if (bus.flush_i) begin
                    pc_d       = bus.new_pc_i;
                    id_pc_d    = '0;
                    id_inst_d  = '0;
                    id_valid_d = 1'b0;
`ifdef IF_ADDR_CHECK_EN
                    id_adel_d  = 1'b0;
`endif
                end else if (bus.stall_i) begin
                    // Hold everything; a branch seen while stalled is re-presented by ID later.
                    pc_d = pc_q;
`ifdef IF_ADDR_CHECK_EN
                end else if (pc_q[1:0] != 2'b00) begin
                    state_d    = S_HALT;
                    id_pc_d    = pc_q;
                    id_inst_d  = '0;
                    id_valid_d = 1'b1;
                    id_adel_d  = 1'b1;
`endif
                end else begin
                    // Delay slot: the instruction at pc is captured even when a branch redirects.
                    id_pc_d    = pc_q;
                    id_inst_d  = bus.rom_inst_i;
                    id_valid_d = 1'b1;
`ifdef IF_ADDR_CHECK_EN
                    id_adel_d  = 1'b0;
`endif
                    pc_d = bus.branch_flag_i ? bus.branch_target_i : pc_q + ADDR_W'(4);
                end
            end

`ifdef IF_ADDR_CHECK_EN
            S_HALT: begin
                if (bus.flush_i) begin
                    state_d    = S_RUN;
                    pc_d       = bus.new_pc_i;
                    id_pc_d    = '0;
                    id_inst_d  = '0;
                    id_valid_d = 1'b0;
                    id_adel_d  = 1'b0;
                end
            end
`endif

            default: begin
                state_d  = S_IDLE;
                rom_ce_d = 1'b0;
                pc_d     = RESET_PC;
            end
        endcase
    end

    // NOTE: every flop has an async reset value, so the stage is fully defined the instant rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rom_ce_q   <= 1'b0;
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
`ifdef IF_ADDR_CHECK_EN
            id_adel_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q    <= state_d;
            rom_ce_q   <= rom_ce_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
`ifdef IF_ADDR_CHECK_EN
            id_adel_q  <= id_adel_d;
`endif
        end
    end

    assign bus.rom_ce_o   = rom_ce_q;
    assign bus.rom_addr_o = pc_q;
    assign bus.id_pc_o    = id_pc_q;
    assign bus.id_inst_o  = id_inst_q;
    assign bus.id_valid_o = id_valid_q;
`ifdef IF_ADDR_CHECK_EN
    assign bus.id_adel_o  = id_adel_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios then randomized control
// traffic against a transaction-level model; honours IF_ADDR_CHECK_EN when defined.
module tb_if_fetch_stage;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    if_fetch_stage_if #(.ADDR_W(32), .INST_W(32)) bus ();

    if_fetch_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM contents: word index i holds i+1; the ROM ignores byte-offset bits.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    assign bus.rom_inst_i = rom_word(bus.rom_addr_o);

    // Reference model: what the stage should hold after each edge.
    bit          m_started;
    bit          m_halted;
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_valid;
    logic        m_adel;

    task automatic model_reset();
        m_started  = 0;
        m_halted   = 0;
        m_pc       = 32'h0;
        m_id_pc    = 32'h0;
        m_id_inst  = 32'h0;
        m_id_valid = 1'b0;
        m_adel     = 1'b0;
    endtask

    task automatic model_nop();
        m_id_pc    = 32'h0;
        m_id_inst  = 32'h0;
        m_id_valid = 1'b0;
    endtask

    task automatic model_edge(input logic s, f, b, input logic [31:0] np, bt);
        bit check_en = 0;
`ifdef IF_ADDR_CHECK_EN
        check_en = 1;
`endif
        if (!m_started) begin
            m_started = 1;
            model_nop();
        end else if (m_halted) begin
            if (f) begin
                m_halted = 0;
                m_pc     = np;
                m_adel   = 1'b0;
                model_nop();
            end
        end else if (f) begin
            m_pc   = np;
            m_adel = 1'b0;
            model_nop();
        end else if (s) begin
            // frozen
        end else if (check_en && (m_pc % 4 != 0)) begin
            m_halted   = 1;
            m_id_pc    = m_pc;
            m_id_inst  = 32'h0;
            m_id_valid = 1'b1;
            m_adel     = 1'b1;
        end else begin
            m_id_pc    = m_pc;
            m_id_inst  = rom_word(m_pc);
            m_id_valid = 1'b1;
            m_adel     = 1'b0;
            m_pc       = b ? bt : m_pc + 32'd4;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ce"},    64'(bus.rom_ce_o),   64'(m_started));
        check({tag, ".addr"},  64'(bus.rom_addr_o), 64'(m_pc));
        check({tag, ".ipc"},   64'(bus.id_pc_o),    64'(m_id_pc));
        check({tag, ".inst"},  64'(bus.id_inst_o),  64'(m_id_inst));
        check({tag, ".valid"}, 64'(bus.id_valid_o), 64'(m_id_valid));
`ifdef IF_ADDR_CHECK_EN
        check({tag, ".adel"},  64'(bus.id_adel_o),  64'(m_adel));
`endif
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next.
    task automatic step(input string tag, input logic s, f, b, input logic [31:0] np, bt);
        bus.stall_i         = s;
        bus.flush_i         = f;
        bus.branch_flag_i   = b;
        bus.new_pc_i        = np;
        bus.branch_target_i = bt;
        model_edge(s, f, b, np, bt);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic        rs, rf, rb;
        logic [31:0] rnp, rbt;

        rst                 = 1'b0;
        bus.stall_i         = 1'b0;
        bus.flush_i         = 1'b0;
        bus.branch_flag_i   = 1'b0;
        bus.new_pc_i        = '0;
        bus.branch_target_i = '0;
        model_reset();

        #3;
        check("rst.ce",    64'(bus.rom_ce_o),   64'd0);
        check("rst.addr",  64'(bus.rom_addr_o), 64'd0);
        check("rst.valid", 64'(bus.id_valid_o), 64'd0);
        check("rst.inst",  64'(bus.id_inst_o),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset release and first fetches
        step("t1.e1", 0, 0, 0, 0, 0);
        check("t1.ce_e1", 64'(bus.rom_ce_o), 64'd1);
        step("t1.e2", 0, 0, 0, 0, 0);
        check("t1.inst_e2", 64'(bus.id_inst_o), 64'd1);
        check("t1.pc_e2",   64'(bus.id_pc_o),   64'd0);
        step("t1.e3", 0, 0, 0, 0, 0);
        check("t1.inst_e3", 64'(bus.id_inst_o), 64'd2);
        check("t1.pc_e3",   64'(bus.id_pc_o),   64'd4);

        // Stall three cycles with pc=8
        for (int i = 0; i < 3; i++) begin
            step("t2.stall", 1, 0, 1, 0, 32'h200);
            check("t2.addr_held", 64'(bus.rom_addr_o), 64'd8);
            check("t2.inst_held", 64'(bus.id_inst_o),  64'd2);
        end
        step("t2.resume", 0, 0, 0, 0, 0);
        check("t2.inst_e4", 64'(bus.id_inst_o),  64'd3);
        check("t2.pc_e4",   64'(bus.id_pc_o),    64'd8);
        check("t2.addr",    64'(bus.rom_addr_o), 64'd12);

        // Branch with delay slot
        step("t3.seq", 0, 0, 0, 0, 0);
        check("t3.addr10", 64'(bus.rom_addr_o), 64'h10);
        step("t3.br", 0, 0, 1, 0, 32'h40);
        check("t3.addr40", 64'(bus.rom_addr_o), 64'h40);
        check("t3.slot_pc", 64'(bus.id_pc_o), 64'h10);
        check("t3.slot_v",  64'(bus.id_valid_o), 64'd1);
        step("t3.tgt", 0, 0, 0, 0, 0);
        check("t3.tgt_pc",   64'(bus.id_pc_o),   64'h40);
        check("t3.tgt_inst", 64'(bus.id_inst_o), 64'h11);

        // Flush beats stall and branch
        step("t4.flush", 1, 1, 1, 32'h180, 32'h300);
        check("t4.addr",  64'(bus.rom_addr_o), 64'h180);
        check("t4.inst",  64'(bus.id_inst_o),  64'd0);
        check("t4.valid", 64'(bus.id_valid_o), 64'd0);

        // PC wrap
        step("t5.flush", 0, 1, 0, 32'hFFFF_FFFC, 0);
        step("t5.wrap", 0, 0, 0, 0, 0);
        check("t5.addr0", 64'(bus.rom_addr_o), 64'h0);
        check("t5.ipc",   64'(bus.id_pc_o),    64'hFFFF_FFFC);

        // Misaligned branch target
        step("t6.br", 0, 0, 1, 0, 32'h42);
        check("t6.addr42", 64'(bus.rom_addr_o), 64'h42);
        step("t6.mis", 0, 0, 0, 0, 0);
        check("t6.ipc", 64'(bus.id_pc_o), 64'h42);
`ifdef IF_ADDR_CHECK_EN
        check("t6.adel",   64'(bus.id_adel_o),  64'd1);
        check("t6.frozen", 64'(bus.rom_addr_o), 64'h42);
        step("t6.halt", 0, 0, 1, 0, 32'h100);
        check("t6.still",  64'(bus.rom_addr_o), 64'h42);
        step("t6.exit", 0, 1, 0, 32'h180, 0);
        check("t6.adel0",  64'(bus.id_adel_o),  64'd0);
        check("t6.addr180", 64'(bus.rom_addr_o), 64'h180);
`else
        check("t6.inst_asis", 64'(bus.id_inst_o), 64'h11);
        check("t6.addr46",    64'(bus.rom_addr_o), 64'h46);
`endif

        // Randomized control traffic
        for (int i = 0; i < 400; i++) begin
            rs  = ($urandom_range(0, 3) == 0);
            rf  = ($urandom_range(0, 11) == 0);
            rb  = ($urandom_range(0, 4) == 0);
            rnp = $urandom & 32'hFFFF_FFFC;
            rbt = $urandom;
            if ($urandom_range(0, 9) != 0)
                rbt = rbt & 32'hFFFF_FFFC;
            step("rnd", rs, rf, rb, rnp, rbt);
        end

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(posedge clk);
        #1;
        check_all("arst.hold");
        rst = 1'b1;
        for (int i = 0; i < 20; i++)
            step("post", 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 0,
                 $urandom & 32'hFFFF_FFFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
